// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot or auto-reload terminal behaviour.
// Q, tc and busy all come straight from registers.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  input  logic             reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] rv_reg, rv_next;
  logic             tc_reg, tc_next;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg <= IDLE;
      q_reg     <= ZERO;
      rv_reg    <= ZERO;
      tc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      rv_reg    <= rv_next;
      tc_reg    <= tc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    rv_next    = rv_reg;
    tc_next    = 1'b0;

    if (load) begin
      // A zero load never arms the counter, so it can never pulse tc.
      q_next     = data;
      rv_next    = data;
      state_next = (data != ZERO) ? RUN : IDLE;
    end else if (state_reg == RUN && enable) begin
      if (q_reg > ONE) begin
        q_next = q_reg - ONE;
      end else if (q_reg == ONE) begin
        tc_next = 1'b1;
        if (reload) begin
          q_next = rv_reg;
        end else begin
          q_next     = ZERO;
          state_next = IDLE;
        end
      end else begin
        // RUN with a zero count is unreachable; fall back to IDLE without a pulse.
        state_next = IDLE;
      end
    end
  end

  assign Q    = q_reg;
  assign tc   = tc_reg;
  assign busy = (state_reg == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one task per scenario, inline checks.
module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic             clock;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             enable;
  logic             reload;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .clear  (clear),
    .load   (load),
    .data   (data),
    .enable (enable),
    .reload (reload),
    .Q      (Q),
    .tc     (tc),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; load = 1'b1; data = 4'd6; enable = 1'b1; reload = 1'b0;
    tick();
    checks++;
    if (Q !== 4'd0) begin errors++; $display("FAIL reset_q got %0d want 0", Q); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got %b want 0", tc); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    clear = 1'b0; load = 1'b0; enable = 1'b0;
    tick();
    checks++;
    if (Q !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold got q=%0d busy=%b want q=0 busy=0", Q, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_one_shot();
    logic [3:0] exp_q [5]  = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    logic       exp_tc[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_bz[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    load = 1'b1; data = 4'd3; reload = 1'b0; enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      load = 1'b0;
      checks++;
      if (Q !== exp_q[i] || tc !== exp_tc[i] || busy !== exp_bz[i]) begin
        errors++;
        $display("FAIL one_shot[%0d] got q=%0d tc=%b busy=%b want q=%0d tc=%b busy=%b",
                 i, Q, tc, busy, exp_q[i], exp_tc[i], exp_bz[i]);
      end
    end
    enable = 1'b0;
    $display("test_one_shot done");
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_q [7] = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    logic       exp_tc[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    load = 1'b1; data = 4'd2; reload = 1'b1; enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      load = 1'b0; enable = 1'b1;
      checks++;
      if (Q !== exp_q[i] || tc !== exp_tc[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL auto_reload[%0d] got q=%0d tc=%b busy=%b want q=%0d tc=%b busy=1",
                 i, Q, tc, busy, exp_q[i], exp_tc[i]);
      end
    end
    enable = 1'b0; reload = 1'b0;
    $display("test_auto_reload done");
  endtask

  task automatic test_reload_one();
    load = 1'b1; data = 4'd1; reload = 1'b1; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Q !== 4'd1 || tc !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL reload_one[%0d] got q=%0d tc=%b busy=%b want q=1 tc=1 busy=1",
                 i, Q, tc, busy);
      end
    end
    enable = 1'b0; reload = 1'b0;
    tick();
    checks++;
    if (tc !== 1'b0 || Q !== 4'd1) begin
      errors++; $display("FAIL reload_one_stop got q=%0d tc=%b want q=1 tc=0", Q, tc);
    end
    $display("test_reload_one done");
  endtask

  task automatic test_pause();
    logic       en_pat[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] exp_q [5] = '{4'd5, 4'd4, 4'd4, 4'd4, 4'd3};
    load = 1'b1; data = 4'd5; reload = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enable = en_pat[i];
      tick();
      load = 1'b0;
      checks++;
      if (Q !== exp_q[i] || tc !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL pause[%0d] got q=%0d tc=%b busy=%b want q=%0d tc=0 busy=1",
                 i, Q, tc, busy, exp_q[i]);
      end
    end
    enable = 1'b0;
    $display("test_pause done");
  endtask

  task automatic test_load_collision();
    load = 1'b1; data = 4'd1; reload = 1'b0; enable = 1'b0;
    tick();
    checks++;
    if (Q !== 4'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL collision_setup got q=%0d busy=%b want q=1 busy=1", Q, busy);
    end
    load = 1'b1; data = 4'd9; enable = 1'b1;
    tick();
    load = 1'b0; enable = 1'b0;
    checks++;
    if (Q !== 4'd9 || tc !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL collision got q=%0d tc=%b busy=%b want q=9 tc=0 busy=1", Q, tc, busy);
    end
    $display("test_load_collision done");
  endtask

  task automatic test_zero_idle();
    load = 1'b1; data = 4'd0; reload = 1'b1; enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      load = 1'b0; enable = 1'b1;
      checks++;
      if (Q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_idle[%0d] got q=%0d tc=%b busy=%b want q=0 tc=0 busy=0",
                 i, Q, tc, busy);
      end
    end
    enable = 1'b0; reload = 1'b0;
    $display("test_zero_idle done");
  endtask

  task automatic test_reset_mid_count();
    load = 1'b1; data = 4'd7; reload = 1'b0; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    tick();
    checks++;
    if (Q !== 4'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_count got q=%0d busy=%b want q=5 busy=1", Q, busy);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (Q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear got q=%0d tc=%b busy=%b want q=0 tc=0 busy=0", Q, tc, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_clear[%0d] got q=%0d tc=%b busy=%b want q=0 tc=0 busy=0",
                 i, Q, tc, busy);
      end
    end
    enable = 1'b0;
    $display("test_reset_mid_count done");
  endtask

  initial begin
    clear = 1'b0; load = 1'b0; data = '0; enable = 1'b0; reload = 1'b0;
    #2;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_reload_one();
    test_pause();
    test_load_collision();
    test_zero_idle();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the count value and load data.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, synchronous, active-high.
REQ-004 load  input  1  load data into count and reload register.
REQ-005 data  input  WIDTH  load value.
REQ-006 enable  input  1  count-down strobe; one decrement per cycle while high in RUN.
REQ-007 reload  input  1  auto-reload mode select, sampled at the terminal edge.
REQ-008 Q  output  WIDTH  current count, registered.
REQ-009 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-010 busy  output  1  high while the state is RUN.

Function
REQ-011 The block SHALL have exactly two states: IDLE (busy=0) and RUN (busy=1).
REQ-012 The block SHALL hold an internal WIDTH-bit reload register RV that is not visible on any port.
REQ-013 Input priority per edge SHALL be: clear, then load, then enable.
REQ-014 load=1 SHALL set Q<=data, RV<=data and tc<=0, in any state.
  - State goes to RUN if data!=0, otherwise IDLE.
REQ-015 RUN, load=0, enable=0: Q, RV and state SHALL hold, and tc<=0.
REQ-016 RUN, load=0, enable=1, Q>1: Q<=Q-1, tc<=0, state stays RUN.
REQ-017 RUN, load=0, enable=1, Q==1, reload=0: Q<=0, tc<=1, state goes to IDLE.
REQ-018 RUN, load=0, enable=1, Q==1, reload=1: Q<=RV, tc<=1, state stays RUN.
REQ-019 IDLE, load=0: Q SHALL hold, enable SHALL be ignored, tc<=0.
REQ-020 tc SHALL never be high for two consecutive cycles unless RV==1 in auto-reload mode.
  - In that case tc is high every enabled cycle.
REQ-021 Q SHALL never wrap below 0; decrement from 0 SHALL be impossible because IDLE ignores enable.
REQ-022 A load of 0 SHALL give Q=0, IDLE and tc=0, and SHALL never produce a terminal pulse.
REQ-023 A load in the same cycle as a would-be terminal edge SHALL take priority.
  - Q=data, tc=0.
REQ-024 Latency SHALL be as follows:
  - load to Q valid: 1 cycle.
  - Terminal enable edge to tc: same edge as Q reaching 0 or RV.
REQ-025 No combinational path SHALL exist from inputs to outputs.

Reset
REQ-026 clear=1 at a rising edge SHALL set Q=0, RV=0, tc=0, busy=0 and state IDLE.
  - clear overrides load and enable.
REQ-027 clear asserted mid-count SHALL abort the count; no tc pulse SHALL be generated on that edge.
REQ-028 After clear deasserts, the block SHALL remain in IDLE until a load with nonzero data.

Verification
REQ-029 One-shot count:
  - Stimulus: clear; load data=3, reload=0; enable held high.
  - Response: Q sequence 3,2,1,0; tc=1 only in the cycle Q becomes 0.
  - Response: busy falls on that same edge, then Q stays 0.
REQ-030 Auto-reload:
  - Stimulus: load data=2, reload=1, enable high for 6 cycles.
  - Response: Q sequence 2,1,2,1,2,1,2; tc pulses on each 1-to-2 edge; busy stays 1.
REQ-031 Pause:
  - Stimulus: load 5, enable pattern 1,0,0,1.
  - Response: Q sequence 5,4,4,4,3; tc=0 throughout.
REQ-032 Load collision:
  - Stimulus: Q=1 in RUN with enable=1, load=1, data=9 on the same edge.
  - Response: Q=9, tc=0, busy=1.
REQ-033 Zero and idle:
  - Stimulus: load data=0, then enable high for 3 cycles.
  - Response: Q=0, busy=0 and tc=0 throughout.
REQ-034 Reset mid-count:
  - Stimulus: load 7, 2 enabled cycles (Q=5), then clear=1 with enable=1.
  - Response: Q=0, busy=0, tc=0; enable afterwards has no effect.
